// File: rtl/rv32i_encoder_pkg.sv
// rv32i_encoder_pkg: RV32I opcode/funct constants and decode-stage field
// codes shared by the encoder and the decode stage.
package rv32i_encoder_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  // load/store/branch codes equal their funct3 where one exists
  localparam logic [2:0] LD_LB    = 3'd0;
  localparam logic [2:0] LD_LH    = 3'd1;
  localparam logic [2:0] LD_LW    = 3'd2;
  localparam logic [2:0] LD_LBU   = 3'd4;
  localparam logic [2:0] LD_LHU   = 3'd5;
  localparam logic [2:0] LD_NONE  = 3'd7;

  localparam logic [1:0] ST_SB    = 2'd0;
  localparam logic [1:0] ST_SH    = 2'd1;
  localparam logic [1:0] ST_SW    = 2'd2;
  localparam logic [1:0] ST_NONE  = 2'd3;

  localparam logic [3:0] BR_BEQ   = 4'd0;
  localparam logic [3:0] BR_BNE   = 4'd1;
  localparam logic [3:0] BR_BLT   = 4'd4;
  localparam logic [3:0] BR_BGE   = 4'd5;
  localparam logic [3:0] BR_BLTU  = 4'd6;
  localparam logic [3:0] BR_BGEU  = 4'd7;
  localparam logic [3:0] BR_JAL   = 4'd8;
  localparam logic [3:0] BR_JALR  = 4'd9;
  localparam logic [3:0] BR_NONE  = 4'd15;

  typedef enum logic [3:0] {
    C_JAL, C_JALR, C_BR, C_ST, C_LD,
    C_LUI, C_AUIPC, C_R, C_I
  } cls_t;

  typedef enum logic {S_IDLE, S_SECOND} fsm_t;

  function automatic logic [2:0] alu_f3(
    input logic [3:0] a
  );
    case (a)
      ALU_SLL:  return 3'b001;
      ALU_SLT:  return 3'b010;
      ALU_SLTU: return 3'b011;
      ALU_XOR:  return 3'b100;
      ALU_SRL:  return 3'b101;
      ALU_SRA:  return 3'b101;
      ALU_OR:   return 3'b110;
      ALU_AND:  return 3'b111;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_encoder_field_pack.sv
// rv32i_field_pack: class select, range check and bit packing of one
// decoded field bundle. ENC_LI_SPLIT_EN enables the LUI+ADDI split.
module rv32i_field_pack
  import rv32i_encoder_pkg::*;
(
  input  logic [3:0]  alucode,
  input  logic        using_r2,
  input  logic        using_pc,
  input  logic        write_reg,
  input  logic [2:0]  info_load,
  input  logic [1:0]  info_store,
  input  logic [3:0]  info_branch,
  input  logic [4:0]  srcreg1_num,
  input  logic [4:0]  srcreg2_num,
  input  logic [4:0]  dstreg_num,
  input  logic [31:0] imm,
  output logic [31:0] ir,
  output logic        err,
  output logic        split,
  output logic [31:0] ir2
);

  cls_t        cls;
  logic [31:0] word;
  logic [19:0] lui_hi;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        i_ok, b_ok, j_ok, sh_ok;
  logic        lo_zero, is_shift;
  logic        rng_bad, wr_bad, alu_bad;
  logic        other_err, lui_lo;

  always_comb begin
    if (info_branch == BR_JAL) cls = C_JAL;
    else if (info_branch == BR_JALR) cls = C_JALR;
    else if (info_branch != BR_NONE) cls = C_BR;
    else if (info_store != ST_NONE) cls = C_ST;
    else if (info_load != LD_NONE) cls = C_LD;
    else if (alucode == ALU_LUI) cls = C_LUI;
    else if (using_pc && alucode == ALU_ADD)
      cls = C_AUIPC;
    else if (using_r2) cls = C_R;
    else cls = C_I;
  end

  assign i_ok  = imm[31:11] == {21{imm[11]}};
  assign b_ok  = !imm[0]
              && imm[31:12] == {20{imm[12]}};
  assign j_ok  = !imm[0]
              && imm[31:20] == {12{imm[20]}};
  assign sh_ok = imm[31:5] == '0;
  assign lo_zero  = imm[11:0] == '0;
  assign is_shift = alucode == ALU_SLL
                 || alucode == ALU_SRL
                 || alucode == ALU_SRA;
  assign f3 = alu_f3(alucode);
  assign f7 = (alucode == ALU_SUB
            || alucode == ALU_SRA) ? F7_ALT : '0;

`ifdef ENC_LI_SPLIT_EN
  // round up so the sign-extended ADDI low part restores imm
  assign lui_hi = imm[31:12] + {19'd0, imm[11]};
`else
  assign lui_hi = imm[31:12];
`endif

  always_comb begin
    word    = NOP;
    rng_bad = 1'b0;
    unique case (cls)
      C_JAL: begin
        word = {imm[20], imm[10:1], imm[11],
                imm[19:12], dstreg_num, OP_JAL};
        rng_bad = !j_ok;
      end
      C_JALR: begin
        word = {imm[11:0], srcreg1_num, 3'b000,
                dstreg_num, OP_JALR};
        rng_bad = !i_ok;
      end
      C_BR: begin
        word = {imm[12], imm[10:5], srcreg2_num,
                srcreg1_num, info_branch[2:0],
                imm[4:1], imm[11], OP_BR};
        rng_bad = !b_ok || info_branch[3]
               || info_branch[2:1] == 2'b01;
      end
      C_ST: begin
        word = {imm[11:5], srcreg2_num, srcreg1_num,
                1'b0, info_store, imm[4:0], OP_STORE};
        rng_bad = !i_ok;
      end
      C_LD: begin
        word = {imm[11:0], srcreg1_num, info_load,
                dstreg_num, OP_LOAD};
        rng_bad = !i_ok || info_load == 3'd3
               || info_load == 3'd6;
      end
      C_LUI: word = {lui_hi, dstreg_num, OP_LUI};
      C_AUIPC: begin
        word = {imm[31:12], dstreg_num, OP_AUIPC};
        rng_bad = !lo_zero;
      end
      C_R: word = {f7, srcreg2_num, srcreg1_num,
                   f3, dstreg_num, OP_REG};
      C_I: begin
        if (is_shift) begin
          word = {f7, imm[4:0], srcreg1_num,
                  f3, dstreg_num, OP_IMM};
          rng_bad = !sh_ok;
        end else begin
          word = {imm[11:0], srcreg1_num,
                  f3, dstreg_num, OP_IMM};
          rng_bad = !i_ok || alucode == ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  assign wr_bad = (cls == C_BR || cls == C_ST)
                ? write_reg : !write_reg;
  assign alu_bad   = alucode > ALU_LUI;
  assign other_err = alu_bad | wr_bad | rng_bad;
  assign lui_lo    = cls == C_LUI && !lo_zero;
  assign ir        = other_err ? NOP : word;
  assign ir2 = {imm[11:0], dstreg_num, 3'b000,
                dstreg_num, OP_IMM};

`ifdef ENC_LI_SPLIT_EN
  assign err   = other_err;
  assign split = lui_lo && !other_err;
`else
  // lossy LUI keeps its upper bits but is flagged
  assign err   = other_err | lui_lo;
  assign split = 1'b0;
`endif

endmodule

// File: rtl/rv32i_encoder.sv
// rv32i_encoder: field bundle -> RV32I word, 2-entry output FIFO.
// ENC_LI_SPLIT_EN adds the SECOND state that emits the split ADDI.
module rv32i_encoder
  import rv32i_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alucode,
  input  logic        using_r2,
  input  logic        using_pc,
  input  logic        write_reg,
  input  logic [2:0]  info_load,
  input  logic [1:0]  info_store,
  input  logic [3:0]  info_branch,
  input  logic [4:0]  srcreg1_num,
  input  logic [4:0]  srcreg2_num,
  input  logic [4:0]  dstreg_num,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ir,
  output logic        out_err
);

  localparam int FIFO_DEPTH = 2;

  logic [31:0] pk_ir, pk_ir2, ir2_q;
  logic        pk_err, pk_split;
  fsm_t        state;
  logic [32:0] mem [FIFO_DEPTH];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        push_in, push_2nd, push, pop;
  logic [32:0] push_data;

  rv32i_field_pack u_pack (
    .alucode     (alucode),
    .using_r2    (using_r2),
    .using_pc    (using_pc),
    .write_reg   (write_reg),
    .info_load   (info_load),
    .info_store  (info_store),
    .info_branch (info_branch),
    .srcreg1_num (srcreg1_num),
    .srcreg2_num (srcreg2_num),
    .dstreg_num  (dstreg_num),
    .imm         (imm),
    .ir          (pk_ir),
    .err         (pk_err),
    .split       (pk_split),
    .ir2         (pk_ir2)
  );

  assign in_ready = !rst && state == S_IDLE
                 && count < 2'(FIFO_DEPTH);
  assign push_in  = in_valid && in_ready;
  assign push_2nd = state == S_SECOND
                 && count < 2'(FIFO_DEPTH);
  assign push = push_in | push_2nd;
  assign pop  = out_ready && count != '0;
  assign push_data = push_2nd ? {1'b0, ir2_q}
                              : {pk_err, pk_ir};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      ir2_q  <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push}
                     - {1'b0, pop};
      unique case (state)
        S_IDLE:
          if (push_in && pk_split) begin
            state <= S_SECOND;
            ir2_q <= pk_ir2;
          end
        S_SECOND:
          if (push_2nd) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign {out_err, out_ir} = mem[rd_ptr];
  assign out_valid = count != '0;

endmodule

// File: tb/tb_rv32i_encoder.sv
// tb_rv32i_encoder: random + directed bench against an arithmetic
// reference encoder and an order-preserving expected-word queue.
module tb_rv32i_encoder;
  import rv32i_encoder_pkg::*;

  typedef struct packed {
    logic [3:0]  alu;
    logic        r2;
    logic        pc;
    logic        wr;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [3:0]  br;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } bund_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  bund_t       cur;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_ir;

  rv32i_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alucode     (cur.alu),
    .using_r2    (cur.r2),
    .using_pc    (cur.pc),
    .write_reg   (cur.wr),
    .info_load   (cur.ld),
    .info_store  (cur.st),
    .info_branch (cur.br),
    .srcreg1_num (cur.rs1),
    .srcreg2_num (cur.rs2),
    .dstreg_num  (cur.rd),
    .imm         (cur.imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ir      (out_ir),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] q[$];
  logic [32:0] got[$];
  int fifo_n = 0;
  bit pending = 0;
  bit last_acc = 0;
  int f3_tab [0:10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7, 0};
  int bnd [0:16] = '{-4097, -4096, -2049, -2048, -1, 0, 1,
                     31, 32, 2047, 2048, 4094, 4095,
                     1048574, 1048576, -1048576, -1048578};

  task automatic check(input string nm,
                       input logic [31:0] a,
                       input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic longint fld(input longint u,
                                 input int lo, input int w);
    return (u >> lo) % (longint'(1) << w);
  endfunction

  // Reference encoder: RV32I field layout from plain arithmetic
  function automatic void ref_enc(input bund_t b,
                                  output logic [32:0] ew,
                                  output bit two,
                                  output logic [31:0] w1);
    longint s, u, w, rd, r1, r2, f3, f7;
    bit bad, lui_lo;
    s = $signed(b.imm);
    u = b.imm;
    rd = b.rd; r1 = b.rs1; r2 = b.rs2;
    bad = b.alu > ALU_LUI;
    lui_lo = 0; two = 0; w1 = '0; w = 0;
    f3 = (b.alu <= ALU_LUI) ? f3_tab[b.alu] : 0;
    f7 = (b.alu == ALU_SUB || b.alu == ALU_SRA) ? 32 : 0;
    if (b.br == BR_JAL) begin
      bad |= (s % 2 != 0) || s < -(1 << 20)
          || s > (1 << 20) - 2 || !b.wr;
      w = (fld(u, 20, 1) << 31) + (fld(u, 1, 10) << 21)
        + (fld(u, 11, 1) << 20) + (fld(u, 12, 8) << 12)
        + (rd << 7) + 'h6F;
    end else if (b.br == BR_JALR) begin
      bad |= s < -2048 || s > 2047 || !b.wr;
      w = (fld(u, 0, 12) << 20) + (r1 << 15)
        + (rd << 7) + 'h67;
    end else if (b.br != BR_NONE) begin
      bad |= (s % 2 != 0) || s < -4096 || s > 4094 || b.wr
          || !(b.br inside {0, 1, 4, 5, 6, 7});
      w = (fld(u, 12, 1) << 31) + (fld(u, 5, 6) << 25)
        + (r2 << 20) + (r1 << 15)
        + ((longint'(b.br) % 8) << 12)
        + (fld(u, 1, 4) << 8) + (fld(u, 11, 1) << 7) + 'h63;
    end else if (b.st != ST_NONE) begin
      bad |= s < -2048 || s > 2047 || b.wr;
      w = (fld(u, 5, 7) << 25) + (r2 << 20) + (r1 << 15)
        + (longint'(b.st) << 12) + (fld(u, 0, 5) << 7) + 'h23;
    end else if (b.ld != LD_NONE) begin
      bad |= s < -2048 || s > 2047 || !b.wr
          || b.ld == 3 || b.ld == 6;
      w = (fld(u, 0, 12) << 20) + (r1 << 15)
        + (longint'(b.ld) << 12) + (rd << 7) + 'h03;
    end else if (b.alu == ALU_LUI) begin
      bad |= !b.wr;
      w = (fld(u, 12, 20) << 12) + (rd << 7) + 'h37;
      if (fld(u, 0, 12) != 0) begin
`ifdef ENC_LI_SPLIT_EN
        w = (fld(u + 2048, 12, 20) << 12) + (rd << 7) + 'h37;
        two = 1;
        w1 = 32'((fld(u, 0, 12) << 20) + (rd << 15)
               + (rd << 7) + 'h13);
`else
        lui_lo = 1;
`endif
      end
    end else if (b.pc && b.alu == ALU_ADD) begin
      bad |= !b.wr || fld(u, 0, 12) != 0;
      w = (fld(u, 12, 20) << 12) + (rd << 7) + 'h17;
    end else if (b.r2) begin
      bad |= !b.wr;
      w = (f7 << 25) + (r2 << 20) + (r1 << 15)
        + (f3 << 12) + (rd << 7) + 'h33;
    end else if (b.alu inside {ALU_SLL, ALU_SRL, ALU_SRA}) begin
      bad |= !b.wr || s < 0 || s > 31;
      w = (f7 << 25) + (fld(u, 0, 5) << 20) + (r1 << 15)
        + (f3 << 12) + (rd << 7) + 'h13;
    end else begin
      bad |= !b.wr || s < -2048 || s > 2047
          || b.alu == ALU_SUB;
      w = (fld(u, 0, 12) << 20) + (r1 << 15)
        + (f3 << 12) + (rd << 7) + 'h13;
    end
    if (bad) begin
      ew = {1'b1, 32'h13};
      two = 0;
    end else begin
      ew = {lui_lo, w[31:0]};
    end
  endfunction

  function automatic bund_t base();
    bund_t b;
    b = '0;
    b.alu = ALU_ADD; b.wr = 1'b1;
    b.ld = LD_NONE; b.st = ST_NONE; b.br = BR_NONE;
    return b;
  endfunction

  function automatic logic [31:0] rnd_imm();
    case ($urandom_range(0, 3))
      0: return 32'(int'($urandom_range(0, 80)) - 40);
      1: return 32'(bnd[$urandom_range(0, 16)]);
      2: return $urandom();
      default: return $urandom() & 32'hFFFF_F000;
    endcase
  endfunction

  function automatic bund_t rnd_b();
    bund_t b;
    b = base();
    b.alu = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 15) == 0)
      b.alu = 4'($urandom_range(0, 15));
    b.rs1 = 5'($urandom()); b.rs2 = 5'($urandom());
    b.rd = 5'($urandom()); b.imm = rnd_imm();
    case ($urandom_range(0, 9))
      0: begin b.br = BR_JAL; b.pc = 1; end
      1: b.br = BR_JALR;
      2: begin b.br = 4'($urandom_range(0, 7)); b.wr = 0; end
      3: begin b.st = 2'($urandom_range(0, 2)); b.wr = 0; end
      4: b.ld = 3'($urandom_range(0, 6));
      5: b.alu = ALU_LUI;
      6: begin b.alu = ALU_ADD; b.pc = 1; end
      7: b.r2 = 1;
      default: ;
    endcase
    if ($urandom_range(0, 15) == 0) b.wr = ~b.wr;
    return b;
  endfunction

  // One clock, entered and left at a falling edge
  task automatic step();
    bit pop, acc, sec, two;
    logic [32:0] ew;
    logic [31:0] w1;
    #1;
    check("out_valid", out_valid, fifo_n > 0);
    check("in_ready", in_ready, !pending && fifo_n < 2);
    pop = fifo_n > 0 && out_ready;
    if (pop) begin
      check("out_ir", out_ir, q[0][31:0]);
      check("out_err", out_err, q[0][32]);
      got.push_back({out_err, out_ir});
      void'(q.pop_front());
    end
    acc = in_valid && !pending && fifo_n < 2;
    two = 0;
    if (acc) begin
      ref_enc(cur, ew, two, w1);
      q.push_back(ew);
      if (two) q.push_back({1'b0, w1});
    end
    sec = pending && fifo_n < 2;
    fifo_n = fifo_n - int'(pop) + int'(acc) + int'(sec);
    if (acc && two) pending = 1;
    else if (sec) pending = 0;
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ir", out_ir, 0);
    check("rst_out_err", out_err, 0);
    q.delete();
    fifo_n = 0;
    pending = 0;
    rst = 1'b0;
  endtask

  task automatic send(input string nm, input bund_t b,
                      input logic [31:0] e_ir,
                      input logic e_err);
    int k;
    got.delete();
    cur = b; in_valid = 1; out_ready = 1;
    k = 0;
    do begin step(); k++; end while (!last_acc && k < 20);
    check({nm, "_acc"}, last_acc, 1);
    in_valid = 0;
    k = 0;
    while (q.size() != 0 && k < 20) begin step(); k++; end
    if (got.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no word got 0 expected 1", nm);
    end else begin
      check({nm, "_ir"}, got[0][31:0], e_ir);
      check({nm, "_err"}, got[0][32], e_err);
    end
  endtask

  initial begin : main
    bund_t b;
    logic [32:0] ew;
    logic [31:0] w1;
    bit two;
    int n, k;
    cur = base();
    @(negedge clk);
    do_reset();

    b = base(); b.r2 = 1; b.rd = 3; b.rs1 = 1; b.rs2 = 2;
    ref_enc(b, ew, two, w1);
    check("pin_add", ew[31:0], 32'h002081B3);
    b = base(); b.br = BR_BEQ; b.wr = 0;
    b.rs1 = 1; b.rs2 = 2; b.imm = 17;
    ref_enc(b, ew, two, w1);
    check("pin_beq17", ew, {1'b1, 32'h13});

    b = base(); b.r2 = 1; b.rd = 3; b.rs1 = 1; b.rs2 = 2;
    send("add", b, 32'h002081B3, 0);
    b = base(); b.rd = 5; b.imm = -1;
    send("addi_m1", b, 32'hFFF00293, 0);
    b.imm = 2048;
    send("addi_2048", b, 32'h00000013, 1);
    b = base(); b.st = ST_SW; b.wr = 0;
    b.rs1 = 1; b.rs2 = 2; b.imm = 8;
    send("sw", b, 32'h0020A423, 0);
    b = base(); b.br = BR_BEQ; b.wr = 0;
    b.rs1 = 1; b.rs2 = 2; b.imm = 16;
    send("beq16", b, 32'h00208863, 0);
    b.imm = 17;
    send("beq17", b, 32'h00000013, 1);
    b = base(); b.alu = ALU_SRA; b.rd = 1; b.rs1 = 2; b.imm = 3;
    send("srai", b, 32'h40315093, 0);
    b = base(); b.br = BR_JAL; b.pc = 1; b.rd = 1; b.imm = 2048;
    send("jal", b, 32'h001000EF, 0);
    b = base(); b.alu = ALU_LUI; b.rd = 1; b.imm = 32'hFFF;
`ifdef ENC_LI_SPLIT_EN
    send("lui_split", b, 32'h000010B7, 0);
    check("lui_words", got.size(), 2);
    if (got.size() == 2)
      check("lui_addi", got[1][31:0], 32'hFFF08093);
`else
    send("lui_lossy", b, 32'h000000B7, 1);
    check("lui_words", got.size(), 1);
`endif

    out_ready = 0; in_valid = 1; n = 0;
    for (int i = 0; i < 6; i++) begin
      cur = base(); cur.r2 = 1; cur.rd = 5'(n + 1);
      step();
      if (last_acc) n++;
    end
    check("bp_accepts", n, 2);
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      cur = base(); cur.r2 = 1; cur.rd = 5'(i + 9);
      step();
    end
    in_valid = 0;
    k = 0;
    while (q.size() != 0 && k < 10) begin step(); k++; end
    check("bp_drain", q.size(), 0);

    out_ready = 0; in_valid = 1;
    cur = base(); cur.r2 = 1; cur.rd = 7;
    step();
    cur = base(); cur.alu = ALU_LUI; cur.rd = 1; cur.imm = 32'hFFF;
    step();
    in_valid = 0;
    step();
    step();
    do_reset();
    got.delete();
    out_ready = 1;
    for (int i = 0; i < 4; i++) step();
    check("rst_flush", got.size(), 0);

    cur = rnd_b();
    for (int c = 0; c < 3000; c++) begin
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 999) == 0) do_reset();
      step();
      if (last_acc) cur = rnd_b();
    end
    in_valid = 0; out_ready = 1;
    k = 0;
    while (q.size() != 0 && k < 10) begin step(); k++; end
    check("final_drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end

endmodule
